// File: rtl/wt_store_wbuf.sv
// Write-through store buffer: in-order issue of committed stores, out-of-order ack retirement,
// word-granular RAW hazard check. Optional store merging into PEND entries: WT_WBUF_MERGE_EN.
module wt_store_wbuf #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TID_W  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_data_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  input  logic                req_nc_i,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_data_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [TID_W-1:0]    mem_tid_o,
  input  logic                ack_valid_i,
  input  logic [TID_W-1:0]    ack_tid_i,
  input  logic [ADDR_W-1:0]   chk_addr_i,
  output logic                chk_hit_o,
  output logic                empty_o,
  output logic                full_o
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(BeW - 1);

  typedef enum logic [1:0] {StFree, StPend, StIssued} slot_state_e;

  slot_state_e         r_state [DEPTH];
  logic [ADDR_W-1:0]   r_addr  [DEPTH];
  logic [DATA_W-1:0]   r_data  [DEPTH];
  logic [BeW-1:0]      r_be    [DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_iss_ptr;

  logic [ADDR_W-1:0]   w_req_word;
  logic [ADDR_W-1:0]   w_chk_word;
  logic                w_issue;
  logic                w_slot_free;
  logic                w_merge_any;
  logic                w_accept;
  logic                w_alloc;
  logic [DEPTH-1:0]    w_ack_hit;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign w_req_word  = req_addr_i & AlignMask;
  assign w_chk_word  = chk_addr_i & AlignMask;
  assign w_issue     = mem_valid_o && mem_ready_i;
  assign w_slot_free = (r_state[r_wr_ptr] == StFree);

`ifdef WT_WBUF_MERGE_EN
  logic            r_nc [DEPTH];
  logic [PtrW-1:0] w_merge_idx;

  // The head entry leaving this cycle must not absorb a store that would then be lost.
  always_comb begin
    w_merge_any = 1'b0;
    w_merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!req_nc_i && (r_state[i] == StPend) && !r_nc[i] && (r_addr[i] == w_req_word) &&
          !(w_issue && (r_iss_ptr == PtrW'(i)))) begin
        w_merge_any = 1'b1;
        w_merge_idx = PtrW'(i);
      end
    end
  end
`else
  logic w_unused_nc;
  assign w_unused_nc = req_nc_i;
  assign w_merge_any = 1'b0;
`endif

  assign req_ready_o = !rst_i && (w_merge_any || w_slot_free);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_alloc     = w_accept && !w_merge_any;

  always_comb begin
    w_ack_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_ack_hit[i] = ack_valid_i && (ack_tid_i == TID_W'(i)) && (r_state[i] == StIssued);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= StFree;
      end
      r_wr_ptr  <= '0;
      r_iss_ptr <= '0;
    end else begin
      // Ack, issue and allocation always touch distinct slots, so their writes never collide.
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ack_hit[i]) begin
          r_state[i] <= StFree;
        end
      end
      if (w_issue) begin
        r_state[r_iss_ptr] <= StIssued;
        r_iss_ptr          <= ptr_inc(r_iss_ptr);
      end
      if (w_alloc) begin
        r_state[r_wr_ptr] <= StPend;
        r_addr[r_wr_ptr]  <= w_req_word;
        r_data[r_wr_ptr]  <= req_data_i;
        r_be[r_wr_ptr]    <= req_be_i;
`ifdef WT_WBUF_MERGE_EN
        r_nc[r_wr_ptr]    <= req_nc_i;
`endif
        r_wr_ptr          <= ptr_inc(r_wr_ptr);
      end
`ifdef WT_WBUF_MERGE_EN
      if (w_accept && w_merge_any) begin
        r_be[w_merge_idx] <= r_be[w_merge_idx] | req_be_i;
        for (int b = 0; b < BeW; b++) begin
          if (req_be_i[b]) begin
            r_data[w_merge_idx][8*b +: 8] <= req_data_i[8*b +: 8];
          end
        end
      end
`endif
    end
  end

  assign mem_valid_o = (r_state[r_iss_ptr] == StPend);
  assign mem_addr_o  = r_addr[r_iss_ptr];
  assign mem_data_o  = r_data[r_iss_ptr];
  assign mem_be_o    = r_be[r_iss_ptr];
  assign mem_tid_o   = TID_W'(r_iss_ptr);

  always_comb begin
    chk_hit_o = 1'b0;
    empty_o   = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_state[i] != StFree) begin
        empty_o = 1'b0;
        if (r_addr[i] == w_chk_word) begin
          chk_hit_o = 1'b1;
        end
      end
    end
  end

  assign full_o = !w_slot_free;

endmodule

// File: tb/tb_wt_store_wbuf.sv
// Bench for wt_store_wbuf: directed scenarios then random traffic against a queue-based model.
module tb_wt_store_wbuf;

  localparam int DEPTH = 2;
`ifdef WT_WBUF_MERGE_EN
  localparam int P0 = 1;
  localparam bit MergeOn = 1'b1;
`else
  localparam int P0 = 0;
  localparam bit MergeOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_be_i;
  logic        req_nc_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_be_o;
  logic [1:0]  mem_tid_o;
  logic        ack_valid_i;
  logic [1:0]  ack_tid_i;
  logic [31:0] chk_addr_i;
  logic        chk_hit_o;
  logic        empty_o;
  logic        full_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wt_store_wbuf dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_be_i(req_be_i), .req_nc_i(req_nc_i),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_be_o(mem_be_o), .mem_tid_o(mem_tid_o),
    .ack_valid_i(ack_valid_i), .ack_tid_i(ack_tid_i), .chk_addr_i(chk_addr_i),
    .chk_hit_o(chk_hit_o), .empty_o(empty_o), .full_o(full_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic nc);
    req_valid_i = 1'b1; req_addr_i = a; req_data_i = d; req_be_i = be; req_nc_i = nc;
  endtask

  // Issue everything outstanding and ack each request one cycle later; returns request count.
  task automatic drain(output int n);
    logic       have;
    logic [1:0] t;
    n = 0; have = 1'b0; t = '0;
    for (int c = 0; c < 8; c++) begin
      ack_valid_i = have; ack_tid_i = t; mem_ready_i = 1'b1;
      #1;
      have = mem_valid_o; t = mem_tid_o;
      if (mem_valid_o) n++;
      @(negedge clk);
    end
    ack_valid_i = 1'b0; mem_ready_i = 1'b0;
  endtask

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

  // Reference model: busy flags per slot, allocation-ordered queue of not-yet-issued slots.
  logic        m_busy [DEPTH];
  logic [31:0] m_addr [DEPTH];
  logic [31:0] m_data [DEPTH];
  logic [3:0]  m_be   [DEPTH];
  logic        m_nc   [DEPTH];
  int          pend_q [$];
  int          m_wr;

  initial begin
    int n;
    logic [31:0] bases [3];
    bases[0] = 32'h100; bases[1] = 32'h104; bases[2] = 32'h200;

    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_be_i = '0;
    req_nc_i = 1'b0; mem_ready_i = 1'b0; ack_valid_i = 1'b0; ack_tid_i = '0; chk_addr_i = '0;
    @(negedge clk);
    #1 chk("ready_in_reset", 64'(req_ready_o), 0);
    @(negedge clk);
    rst_i = 1'b0; chk_addr_i = 32'h0;
    #1;
    chk("rst_mem_valid", 64'(mem_valid_o), 0);
    chk("rst_chk_hit", 64'(chk_hit_o), 0);
    chk("rst_empty", 64'(empty_o), 1);
    chk("rst_full", 64'(full_o), 0);
    chk("rst_ready", 64'(req_ready_o), 1);

    // Ordered drain
    mem_ready_i = 1'b1;
    store(32'h100, 32'h11, 4'h1, 1'b0);
    #1 chk("od_valid_latency", 64'(mem_valid_o), 0);
    @(negedge clk);
    store(32'h200, 32'h22, 4'h1, 1'b0);
    #1;
    chk("od_addr0", 64'(mem_addr_o), 64'h100);
    chk("od_tid0", 64'(mem_tid_o), 0);
    chk("od_ready2", 64'(req_ready_o), 1);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    chk("od_addr1", 64'(mem_addr_o), 64'h200);
    chk("od_tid1", 64'(mem_tid_o), 1);
    chk("od_full_a", 64'(full_o), 1);
    @(negedge clk);
    mem_ready_i = 1'b0; ack_valid_i = 1'b1; ack_tid_i = 2'd0;
    #1;
    chk("od_idle_valid", 64'(mem_valid_o), 0);
    chk("od_full_b", 64'(full_o), 1);
    chk("od_ack_no_bypass", 64'(req_ready_o), 0);
    @(negedge clk);
    ack_tid_i = 2'd1;
    #1;
    chk("od_full_after_ack", 64'(full_o), 0);
    chk("od_not_empty", 64'(empty_o), 0);
    @(negedge clk);
    ack_valid_i = 1'b0;
    #1 chk("od_empty", 64'(empty_o), 1);

    // Merge (or two entries without merging)
    store(32'h100, 32'h000000AA, 4'h1, 1'b0);
    @(negedge clk);
    store(32'h102, 32'h00CC0000, 4'h4, 1'b0);
    #1;
    chk("mg_ready", 64'(req_ready_o), 1);
    chk("mg_head_data", 64'(mem_data_o), 64'hAA);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    chk("mg_data", 64'(mem_data_o), MergeOn ? 64'h00CC00AA : 64'hAA);
    chk("mg_be", 64'(mem_be_o), MergeOn ? 64'h5 : 64'h1);
    chk("mg_full", 64'(full_o), MergeOn ? 0 : 1);
    drain(n);
    chk("mg_req_count", 64'(n), MergeOn ? 1 : 2);
    chk("mg_empty", 64'(empty_o), 1);

    // Non-cacheable stores never merge
    store(32'h100, 32'h000000AA, 4'h1, 1'b1);
    @(negedge clk);
    store(32'h102, 32'h00CC0000, 4'h4, 1'b1);
    @(negedge clk);
    req_valid_i = 1'b0; req_nc_i = 1'b0;
    #1;
    chk("nc_full", 64'(full_o), 1);
    chk("nc_be", 64'(mem_be_o), 1);
    drain(n);
    chk("nc_req_count", 64'(n), 2);

    // Out-of-order ack
    mem_ready_i = 1'b1;
    store(32'h300, 32'h3, 4'hF, 1'b0);
    @(negedge clk);
    store(32'h400, 32'h4, 4'hF, 1'b0);
    #1 chk("oo_tid_a", 64'(mem_tid_o), 64'(P0));
    @(negedge clk);
    req_valid_i = 1'b0;
    #1 chk("oo_tid_b", 64'(mem_tid_o), 64'(P0 ^ 1));
    @(negedge clk);
    ack_valid_i = 1'b1; ack_tid_i = 2'(P0 ^ 1);
    @(negedge clk);
    ack_valid_i = 1'b0;
    store(32'h500, 32'h5, 4'hF, 1'b0);
    #1;
    chk("oo_full", 64'(full_o), 1);
    chk("oo_blocked", 64'(req_ready_o), 0);
    @(negedge clk);
    ack_valid_i = 1'b1; ack_tid_i = 2'(P0);
    #1 chk("oo_blocked_ack", 64'(req_ready_o), 0);
    @(negedge clk);
    ack_valid_i = 1'b0;
    #1 chk("oo_accept", 64'(req_ready_o), 1);
    @(negedge clk);
    req_valid_i = 1'b0;
    #1;
    chk("oo_c_addr", 64'(mem_addr_o), 64'h500);
    chk("oo_c_tid", 64'(mem_tid_o), 64'(P0));
    @(negedge clk);
    mem_ready_i = 1'b0; ack_valid_i = 1'b1; ack_tid_i = 2'(P0);
    @(negedge clk);
    ack_valid_i = 1'b0;
    #1 chk("oo_empty", 64'(empty_o), 1);

    // Hazard check and spurious ack on a PEND entry
    store(32'h100, 32'h55, 4'hF, 1'b0);
    @(negedge clk);
    req_valid_i = 1'b0; chk_addr_i = 32'h103;
    #1 chk("hz_hit_same_word", 64'(chk_hit_o), 1);
    chk_addr_i = 32'h104;
    #1 chk("hz_miss_next_word", 64'(chk_hit_o), 0);
    ack_valid_i = 1'b1; ack_tid_i = 2'(P0 ^ 1);
    @(negedge clk);
    ack_valid_i = 1'b0; mem_ready_i = 1'b1;
    #1;
    chk("hz_still_pend", 64'(mem_valid_o), 1);
    chk("hz_tid", 64'(mem_tid_o), 64'(P0 ^ 1));
    @(negedge clk);
    mem_ready_i = 1'b0; chk_addr_i = 32'h100;
    #1;
    chk("hz_issued_valid", 64'(mem_valid_o), 0);
    chk("hz_issued_hit", 64'(chk_hit_o), 1);

    // Reset with an entry in flight
    rst_i = 1'b1;
    #1 chk("rm_ready", 64'(req_ready_o), 0);
    @(negedge clk);
    rst_i = 1'b0; ack_valid_i = 1'b1; ack_tid_i = 2'(P0 ^ 1);
    #1;
    chk("rm_empty", 64'(empty_o), 1);
    chk("rm_valid", 64'(mem_valid_o), 0);
    chk("rm_hit", 64'(chk_hit_o), 0);
    @(negedge clk);
    ack_valid_i = 1'b0;
    #1;
    chk("rm_late_ack_empty", 64'(empty_o), 1);
    chk("rm_late_ack_full", 64'(full_o), 0);

    // Random traffic; pointers are back at 0 after the reset above.
    for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
    pend_q.delete();
    m_wr = 0;
    for (int c = 0; c < 800; c++) begin
      logic [31:0] word;
      logic        issue_now, exp_ready, exp_hit, exp_empty, in_pend;
      int          merge_s, tid, head;
      rst_i       = ($urandom_range(0, 79) == 0);
      req_valid_i = 1'($urandom_range(0, 1));
      req_addr_i  = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 3));
      req_data_i  = $urandom;
      req_be_i    = 4'($urandom_range(1, 15));
      req_nc_i    = ($urandom_range(0, 3) == 0);
      mem_ready_i = 1'($urandom_range(0, 1));
      ack_valid_i = 1'($urandom_range(0, 1));
      ack_tid_i   = 2'($urandom_range(0, 3));
      chk_addr_i  = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 3));
      #1;
      word = req_addr_i & ~32'h3;
      issue_now = (pend_q.size() != 0) && mem_ready_i;
      merge_s = -1;
      if (MergeOn && !req_nc_i) begin
        foreach (pend_q[k]) begin
          if (!(issue_now && k == 0) && !m_nc[pend_q[k]] && m_addr[pend_q[k]] == word)
            merge_s = pend_q[k];
        end
      end
      exp_ready = !rst_i && (merge_s >= 0 || !m_busy[m_wr]);
      exp_hit = 1'b0; exp_empty = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_busy[i]) begin
          exp_empty = 1'b0;
          if (m_addr[i] == (chk_addr_i & ~32'h3)) exp_hit = 1'b1;
        end
      end
      chk("rnd_ready", 64'(req_ready_o), 64'(exp_ready));
      chk("rnd_mem_valid", 64'(mem_valid_o), 64'(pend_q.size() != 0));
      if (pend_q.size() != 0) begin
        head = pend_q[0];
        chk("rnd_mem_addr", 64'(mem_addr_o), 64'(m_addr[head]));
        chk("rnd_mem_data", 64'(mem_data_o), 64'(m_data[head]));
        chk("rnd_mem_be", 64'(mem_be_o), 64'(m_be[head]));
        chk("rnd_mem_tid", 64'(mem_tid_o), 64'(head));
      end
      chk("rnd_chk_hit", 64'(chk_hit_o), 64'(exp_hit));
      chk("rnd_empty", 64'(empty_o), 64'(exp_empty));
      chk("rnd_full", 64'(full_o), 64'(m_busy[m_wr]));

      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
        pend_q.delete();
        m_wr = 0;
      end else begin
        tid = int'(ack_tid_i);
        if (ack_valid_i && tid < DEPTH && m_busy[tid]) begin
          in_pend = 1'b0;
          foreach (pend_q[k]) if (pend_q[k] == tid) in_pend = 1'b1;
          if (!in_pend) m_busy[tid] = 1'b0;
        end
        if (issue_now) void'(pend_q.pop_front());
        if (req_valid_i && exp_ready) begin
          if (merge_s >= 0) begin
            m_be[merge_s]   = m_be[merge_s] | req_be_i;
            m_data[merge_s] = (m_data[merge_s] & ~be_mask(req_be_i)) |
                              (req_data_i & be_mask(req_be_i));
          end else begin
            m_busy[m_wr] = 1'b1;
            m_addr[m_wr] = word;
            m_data[m_wr] = req_data_i;
            m_be[m_wr]   = req_be_i;
            m_nc[m_wr]   = req_nc_i;
            pend_q.push_back(m_wr);
            m_wr = (m_wr + 1) % DEPTH;
          end
        end
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
